// File: rtl/wb_regfile.sv
// Write-back stage: selects the commit value and owns the 32x32 register file.
// Read ports bypass the pending write so ID sees it in the same cycle.
module wb_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] iResult,
   input  logic [31:0] iControlSignal,
   input  logic [4:0]  iRegAddress,
   input  logic [31:0] iReadData,
   input  logic [31:0] iPC_plus_4,
   input  logic [4:0]  iReadAddr1,
   input  logic [4:0]  iReadAddr2,
   output logic [31:0] oReadData1,
   output logic [31:0] oReadData2,
   output logic [31:0] oWbData,
   output logic [4:0]  oWbAddr,
   output logic        oWbEn
);

   logic        reg_write;
   logic [1:0]  mem_to_reg;
   logic [1:0]  load_size;
   logic        unused_ctrl;

   assign reg_write   = iControlSignal[0];
   assign mem_to_reg  = iControlSignal[2:1];
   assign load_size   = iControlSignal[4:3];
   assign unused_ctrl = ^iControlSignal[31:5];

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   always_comb begin
      ld_byte = iReadData[7:0];
      unique case (iResult[1:0])
         2'b00: ld_byte = iReadData[7:0];
         2'b01: ld_byte = iReadData[15:8];
         2'b10: ld_byte = iReadData[23:16];
         2'b11: ld_byte = iReadData[31:24];
         default: ld_byte = iReadData[7:0];
      endcase
   end

   // Halfword lane ignores iResult[0]; misalignment is not trapped here
   assign ld_half = iResult[1] ? iReadData[31:16] : iReadData[15:0];

   always_comb begin
      ld_data = iReadData;
      unique case (load_size)
         2'b00: ld_data = iReadData;
         2'b01: ld_data = {{24{ld_byte[7]}}, ld_byte};
         2'b10: ld_data = {24'd0, ld_byte};
         2'b11: ld_data = {{16{ld_half[15]}}, ld_half};
         default: ld_data = iReadData;
      endcase
   end

   always_comb begin
      oWbData = iResult;
      unique case (mem_to_reg)
         2'b01:   oWbData = ld_data;
         2'b10:   oWbData = iPC_plus_4;
         default: oWbData = iResult;
      endcase
   end

   assign oWbAddr = iRegAddress;
   assign oWbEn   = reg_write & (|iRegAddress);

   logic [31:0] regs [32];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (oWbEn) begin
         regs[iRegAddress] <= oWbData;
      end
   end

   always_comb begin
      oReadData1 = regs[iReadAddr1];
      if (iReadAddr1 == 5'd0)
         oReadData1 = '0;
      else if (oWbEn && (iReadAddr1 == oWbAddr))
         oReadData1 = oWbData;
   end

   always_comb begin
      oReadData2 = regs[iReadAddr2];
      if (iReadAddr2 == 5'd0)
         oReadData2 = '0;
      else if (oWbEn && (iReadAddr2 == oWbAddr))
         oReadData2 = oWbData;
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vectors, an array model of the register
// file, and a per-cycle compare of every output against that model.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] iResult, iControlSignal, iReadData, iPC_plus_4;
   logic [4:0]  iRegAddress, iReadAddr1, iReadAddr2;
   logic [31:0] oReadData1, oReadData2, oWbData;
   logic [4:0]  oWbAddr;
   logic        oWbEn;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk(clk),
      .reset(reset),
      .iResult(iResult),
      .iControlSignal(iControlSignal),
      .iRegAddress(iRegAddress),
      .iReadData(iReadData),
      .iPC_plus_4(iPC_plus_4),
      .iReadAddr1(iReadAddr1),
      .iReadAddr2(iReadAddr2),
      .oReadData1(oReadData1),
      .oReadData2(oReadData2),
      .oWbData(oWbData),
      .oWbAddr(oWbAddr),
      .oWbEn(oWbEn)
   );

   logic [31:0] m_regs [32];

   function automatic logic [31:0] exp_wb();
      logic [31:0] sh;
      int          b, h;
      logic [31:0] ld;
      sh = iReadData >> (8 * iResult[1:0]);
      b  = int'(sh & 32'hFF);
      sh = iReadData >> (16 * iResult[1]);
      h  = int'(sh & 32'hFFFF);
      case (iControlSignal[4:3])
         2'd0: ld = iReadData;
         2'd1: ld = 32'(b >= 128 ? b - 256 : b);
         2'd2: ld = 32'(b);
         default: ld = 32'(h >= 32768 ? h - 65536 : h);
      endcase
      case (iControlSignal[2:1])
         2'd1: return ld;
         2'd2: return iPC_plus_4;
         default: return iResult;
      endcase
   endfunction

   function automatic logic exp_en();
      return iControlSignal[0] && iRegAddress != 0;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (exp_en() && a == iRegAddress) return exp_wb();
      return m_regs[a];
   endfunction

   initial for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

   always @(posedge clk or posedge reset) begin
      if (reset)
         for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      else if (exp_en())
         m_regs[iRegAddress] <= exp_wb();
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("wbdata", oWbData, exp_wb());
      chk("wbaddr", 32'(oWbAddr), 32'(iRegAddress));
      chk("wben", 32'(oWbEn), 32'(exp_en()));
      chk("rd1", oReadData1, exp_rd(iReadAddr1));
      chk("rd2", oReadData2, exp_rd(iReadAddr2));
   end

   task automatic drive(input logic [31:0] ctrl, input logic [31:0] res,
                        input logic [31:0] rdat, input logic [31:0] pc,
                        input logic [4:0] wa, input logic [4:0] r1,
                        input logic [4:0] r2);
      iControlSignal = ctrl;
      iResult        = res;
      iReadData      = rdat;
      iPC_plus_4     = pc;
      iRegAddress    = wa;
      iReadAddr1     = r1;
      iReadAddr2     = r2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 5, 0);
      #1 reset = 1'b1;
      mid();
      chk("rst_wbdata", oWbData, 32'd0);
      chk("rst_wbaddr", 32'(oWbAddr), 32'd0);
      chk("rst_wben", 32'(oWbEn), 32'd0);
      chk("rst_rd1", oReadData1, 32'd0);
      reset = 1'b0;
      step();

      // reset clears a stored value between edges
      drive(1, 32'hDEADBEEF, 0, 0, 5, 5, 0);
      step();
      drive(0, 0, 0, 0, 0, 5, 5);
      mid();
      chk("pre_rst", oReadData1, 32'hDEADBEEF);
      reset = 1'b1;
      #1 chk("rst_async", oReadData1, 32'd0);
      reset = 1'b0;
      drive(1, 32'h55, 0, 0, 5, 5, 0);
      step();
      drive(0, 0, 0, 0, 0, 5, 0);
      #1 chk("post_rst_wr", oReadData1, 32'h55);

      // write coinciding with an edge under reset is dropped
      drive(1, 32'h66, 0, 0, 6, 6, 5);
      mid();
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 6, 5);
      #1;
      chk("rst_drop", oReadData1, 32'd0);
      chk("rst_drop5", oReadData2, 32'd0);

      // result write with bypass
      drive(1, 32'h12345678, 0, 0, 9, 9, 0);
      #1 chk("byp_9", oReadData1, 32'h12345678);
      step();
      drive(0, 0, 0, 0, 9, 9, 0);
      #1 chk("stored_9", oReadData1, 32'h12345678);

      // load extraction
      drive(32'h0A, 32'h1, 32'h80FF7F01, 0, 0, 0, 0);
      #1 chk("lb_01", oWbData, 32'h0000007F);
      drive(32'h0A, 32'h2, 32'h80FF7F01, 0, 0, 0, 0);
      #1 chk("lb_10", oWbData, 32'hFFFFFFFF);
      drive(32'h12, 32'h3, 32'h80FF7F01, 0, 0, 0, 0);
      #1 chk("lbu_11", oWbData, 32'h00000080);
      drive(32'h1A, 32'h3, 32'h80FF7F01, 0, 0, 0, 0);
      #1 chk("lh_hi", oWbData, 32'hFFFF80FF);
      drive(32'hFFFFFFE2, 32'h3, 32'h80FF7F01, 0, 0, 0, 0);
      #1 chk("lw", oWbData, 32'h80FF7F01);
      drive(32'h06, 32'h77, 32'h80FF7F01, 32'h4, 0, 0, 0);
      #1 chk("m2r_rsvd", oWbData, 32'h77);
      step();

      // link write keeps the supervisor bit
      drive(32'h5, 32'h1, 0, 32'h80000044, 31, 0, 31);
      step();
      drive(0, 0, 0, 0, 0, 0, 31);
      #1 chk("link_31", oReadData2, 32'h80000044);

      // $0 protection
      drive(1, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
      #1;
      chk("r0_wben", 32'(oWbEn), 32'd0);
      chk("r0_rd1", oReadData1, 32'd0);
      chk("r0_rd2", oReadData2, 32'd0);
      step();
      chk("r0_rd1_post", oReadData1, 32'd0);
      chk("r0_rd2_post", oReadData2, 32'd0);

      // dual port with simultaneous write
      drive(1, 32'hA, 0, 0, 3, 0, 0);
      step();
      drive(1, 32'hB, 0, 0, 4, 0, 0);
      step();
      drive(1, 32'hC, 0, 0, 4, 3, 4);
      #1;
      chk("dual_rd1", oReadData1, 32'hA);
      chk("dual_rd2", oReadData2, 32'hC);
      step();

      // back-to-back writes, later wins
      drive(1, 32'h1, 0, 0, 7, 7, 7);
      #1 chk("b2b_1", oReadData2, 32'h1);
      step();
      drive(1, 32'h2, 0, 0, 7, 7, 7);
      #1 chk("b2b_2", oReadData1, 32'h2);
      step();
      drive(0, 0, 0, 0, 0, 7, 7);
      #1 chk("b2b_final", oReadData1, 32'h2);

      // fill every register, then sweep both ports
      for (int i = 1; i < 32; i++) begin
         drive(1, 32'h0101_0101 * i ^ 32'hA5A5_5A5A, 0, 0, 5'(i),
               5'(i), 5'((i + 1) % 32));
         step();
      end
      for (int i = 0; i < 32; i++) begin
         drive(0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
         step();
      end
      drive(0, 0, 0, 0, 0, 12, 0);
      #1 chk("fill_12", oReadData1, 32'h0C0C_0C0C ^ 32'hA5A5_5A5A);

      mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
